f2_fifo_reader: RTL

Dual-lane in-order reader for the two-read-port FIFO used between model stages in the cosim path. It pops zero, one or two entries per cycle from the FIFO head and holds them in a two-slot output register stage. The stage presents the entries to a downstream consumer over per-lane valid/ready handshakes and preserves strict program order across lanes. It also keeps accept and stall statistic counters for cosim reporting.

---
 rtl/f2_fifo_reader_if.sv | 45 ++++
 rtl/f2_fifo_reader.sv | 107 ++++++++++
 2 files changed

// File: rtl/f2_fifo_reader_if.sv
// f2_fifo_reader_if
// Groups every f2_fifo_reader signal except clk/rst.
//   FIFO side     : fifo_num_i, fifo_rdata0_i, fifo_rdata1_i -> reader
//                   fifo_rd0_en_o, fifo_rd1_en_o             <- reader
//   consumer side : out_valid*_o, out_data*_o               <- reader
//                   out_ready*_i                            -> reader
//   control/stats : flush_i -> reader; accept_cnt_o, stall_cnt_o <- reader
// Handshake: lane k transfers an entry in a cycle where out_validk_o and
// out_readyk_i are both high at the clock edge; lane 1 transfers only when
// lane 0 transfers in the same cycle.
// Modports: master = the reader itself, slave = its environment.
interface f2_fifo_reader_if #(
  parameter int DATA_WIDTH = 5,
  parameter int CNT_WIDTH  = 6,
  parameter int STAT_WIDTH = 32
);
  logic                  flush_i;
  logic [CNT_WIDTH-1:0]  fifo_num_i;
  logic [DATA_WIDTH-1:0] fifo_rdata0_i;
  logic [DATA_WIDTH-1:0] fifo_rdata1_i;
  logic                  fifo_rd0_en_o;
  logic                  fifo_rd1_en_o;
  logic                  out_valid0_o;
  logic [DATA_WIDTH-1:0] out_data0_o;
  logic                  out_valid1_o;
  logic [DATA_WIDTH-1:0] out_data1_o;
  logic                  out_ready0_i;
  logic                  out_ready1_i;
  logic [STAT_WIDTH-1:0] accept_cnt_o;
  logic [STAT_WIDTH-1:0] stall_cnt_o;

  modport master (
    input  flush_i, fifo_num_i, fifo_rdata0_i, fifo_rdata1_i,
           out_ready0_i, out_ready1_i,
    output fifo_rd0_en_o, fifo_rd1_en_o, out_valid0_o, out_data0_o,
           out_valid1_o, out_data1_o, accept_cnt_o, stall_cnt_o
  );

  modport slave (
    output flush_i, fifo_num_i, fifo_rdata0_i, fifo_rdata1_i,
           out_ready0_i, out_ready1_i,
    input  fifo_rd0_en_o, fifo_rd1_en_o, out_valid0_o, out_data0_o,
           out_valid1_o, out_data1_o, accept_cnt_o, stall_cnt_o
  );
endinterface

// File: rtl/f2_fifo_reader.sv
// f2_fifo_reader
// Dual-lane in-order reader for a two-read-port FIFO. Pops 0..2 entries per
// cycle into a two-slot output stage (slot0 older, slot1 younger) and keeps
// accept/stall statistics.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - f2_fifo_reader_if.master (FIFO pop side, consumer handshake,
//          flush and statistic counters)
module f2_fifo_reader #(
  parameter int DATA_WIDTH = 5,
  parameter int CNT_WIDTH  = 6,
  parameter int STAT_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  f2_fifo_reader_if.master  bus
);

  logic                  r_valid0;
  logic                  r_valid1;
  logic [DATA_WIDTH-1:0] r_data0;
  logic [DATA_WIDTH-1:0] r_data1;
  logic [STAT_WIDTH-1:0] r_accept_cnt;
  logic [STAT_WIDTH-1:0] r_stall_cnt;

  logic       w_take0;
  logic       w_take1;
  logic       w_stall;
  logic [1:0] w_occ;
  logic [1:0] w_ntake;
  logic [1:0] w_rem;
  logic [1:0] w_free;
  logic [1:0] w_num_sat;
  logic [1:0] w_pop;

  // Lane 1 may only transfer alongside lane 0 to keep program order.
  assign w_take0 = r_valid0 & bus.out_ready0_i;
  assign w_take1 = r_valid1 & bus.out_ready1_i & w_take0;
  assign w_stall = r_valid0 & ~bus.out_ready0_i;

  // Pop count uses only registered valids, readies and occupancy so the
  // enables never depend on the FIFO read data.
  always_comb begin
    w_occ     = {1'b0, r_valid0} + {1'b0, r_valid1};
    w_ntake   = {1'b0, w_take0} + {1'b0, w_take1};
    w_rem     = w_occ - w_ntake;
    w_free    = 2'd2 - w_rem;
    w_num_sat = (bus.fifo_num_i >= CNT_WIDTH'(2)) ? 2'd2 : bus.fifo_num_i[1:0];
    w_pop     = (w_free < w_num_sat) ? w_free : w_num_sat;
    if (rst || bus.flush_i) begin
      w_pop = 2'd0;
    end
  end

  assign bus.fifo_rd0_en_o = (w_pop != 2'd0);
  assign bus.fifo_rd1_en_o = (w_pop == 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid0     <= 1'b0;
      r_valid1     <= 1'b0;
      r_data0      <= '0;
      r_data1      <= '0;
      r_accept_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      // Statistics keep counting through a flush.
      r_accept_cnt <= r_accept_cnt + STAT_WIDTH'(w_ntake);
      r_stall_cnt  <= r_stall_cnt + STAT_WIDTH'(w_stall);
      if (bus.flush_i) begin
        r_valid0 <= 1'b0;
        r_valid1 <= 1'b0;
      end else begin
        // Data registers load only from popped or surviving entries, so
        // stale or undefined FIFO data never lands in a valid slot.
        case (w_rem)
          2'd0: begin
            r_valid0 <= (w_pop != 2'd0);
            r_valid1 <= (w_pop == 2'd2);
            if (w_pop != 2'd0) r_data0 <= bus.fifo_rdata0_i;
            if (w_pop == 2'd2) r_data1 <= bus.fifo_rdata1_i;
          end
          2'd1: begin
            // Survivor is slot1 when slot0 left, otherwise slot0 itself.
            r_valid0 <= 1'b1;
            if (w_take0) r_data0 <= r_data1;
            r_valid1 <= (w_pop != 2'd0);
            if (w_pop != 2'd0) r_data1 <= bus.fifo_rdata0_i;
          end
          default: begin
            r_valid0 <= r_valid0;
            r_valid1 <= r_valid1;
          end
        endcase
      end
    end
  end

  assign bus.out_valid0_o = r_valid0;
  assign bus.out_valid1_o = r_valid1;
  assign bus.out_data0_o  = r_data0;
  assign bus.out_data1_o  = r_data1;
  assign bus.accept_cnt_o = r_accept_cnt;
  assign bus.stall_cnt_o  = r_stall_cnt;

endmodule
